// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fifo_wr_arbiter                                                 |
// | Purpose  : Round-robin arbiter sharing one registered fifo write port.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int PTR_WIDTH  = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_write,
  output logic [DATA_WIDTH-1:0]         fifo_input_data,
  input  logic                          fifo_full,
  output logic [31:0]                   accept_count
);

  localparam logic [PTR_WIDTH-1:0] c_LAST_IDX = PTR_WIDTH'(NUM_REQ - 1);

  logic [PTR_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic                  fifo_write_q, fifo_write_d;
  logic [DATA_WIDTH-1:0] fifo_data_q, fifo_data_d;
  logic [31:0]           accept_count_q, accept_count_d;

  logic [PTR_WIDTH-1:0]  w_hi_idx, w_lo_idx, w_grant_idx;
  logic                  w_hi_vld, w_lo_vld;
  logic                  w_slot_free, w_accept, w_consume;
  logic [DATA_WIDTH-1:0] w_sel_data;

  // Lowest valid index at or above the pointer wins; otherwise wrap to the lowest valid index.
  always_comb begin
    w_hi_vld = 1'b0;
    w_lo_vld = 1'b0;
    w_hi_idx = '0;
    w_lo_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_lo_vld = 1'b1;
        w_lo_idx = PTR_WIDTH'(i);
        if (PTR_WIDTH'(i) >= rr_ptr_q) begin
          w_hi_vld = 1'b1;
          w_hi_idx = PTR_WIDTH'(i);
        end
      end
    end
    w_grant_idx = w_hi_vld ? w_hi_idx : w_lo_idx;
  end

  assign w_slot_free = !fifo_write_q || !fifo_full;
  assign w_accept    = w_lo_vld && w_slot_free && !reset;
  assign w_consume   = fifo_write_q && !fifo_full;

  always_comb begin
    req_ready  = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == PTR_WIDTH'(i)) begin
        req_ready[i] = w_accept;
        w_sel_data   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    fifo_write_d   = fifo_write_q;
    fifo_data_d    = fifo_data_q;
    rr_ptr_d       = rr_ptr_q;
    accept_count_d = accept_count_q;
    if (w_consume) begin
      accept_count_d = accept_count_q + 32'd1;
    end
    if (w_accept) begin
      fifo_write_d = 1'b1;
      fifo_data_d  = w_sel_data;
      rr_ptr_d     = (w_grant_idx == c_LAST_IDX) ? '0 : w_grant_idx + PTR_WIDTH'(1);
    end else if (w_consume) begin
      fifo_write_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q       <= '0;
      fifo_write_q   <= 1'b0;
      fifo_data_q    <= '0;
      accept_count_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      fifo_write_q   <= fifo_write_d;
      fifo_data_q    <= fifo_data_d;
      accept_count_q <= accept_count_d;
    end
  end

  assign fifo_write      = fifo_write_q;
  assign fifo_input_data = fifo_data_q;
  assign accept_count    = accept_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fifo_wr_arbiter                                              |
// | Purpose  : Self-checking bench for fifo_wr_arbiter (4- and 3-requester).   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_fifo_wr_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   v4, rdy4;
  logic [127:0] d4;
  logic         full4, wr4;
  logic [31:0]  od4, cnt4;
  logic [2:0]   v3, rdy3;
  logic [95:0]  d3;
  logic         full3, wr3;
  logic [31:0]  od3, cnt3;

  int checks = 0;
  int failures = 0;

  // Behavioural model state, index 0 = 4-requester DUT, 1 = 3-requester DUT
  logic        m_wr[2];
  logic [31:0] m_dat[2];
  logic [31:0] m_cnt[2];
  int          m_ptr[2];

  logic [3:0]  rdy4_seen;
  logic [31:0] got4[$], got3[$], fifo_q[$], outq[$];
  logic [3:0]  auto_en;
  logic        fill_mode;
  int          rq_cnt[4];
  int          base[4];
  int          stride, lim;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .PTR_WIDTH(3)) u_dut4 (
    .clk(clk), .reset(reset), .req_valid(v4), .req_data(d4), .req_ready(rdy4),
    .fifo_write(wr4), .fifo_input_data(od4), .fifo_full(full4), .accept_count(cnt4)
  );

  fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(32), .PTR_WIDTH(2)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(v3), .req_data(d3), .req_ready(rdy3),
    .fifo_write(wr3), .fifo_input_data(od3), .fifo_full(full3), .accept_count(cnt3)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare one DUT against the model, then advance the model across the coming edge.
  task automatic model_chk(input int id, input int n, input logic [7:0] v, input logic [255:0] dat,
                           input logic full, input logic [7:0] rdy, input logic wr,
                           input logic [31:0] od, input logic [31:0] cnt);
    int g;
    logic [7:0] er;
    string p;
    g  = -1;
    er = '0;
    p  = (id == 0) ? "dut4" : "dut3";
    if (!reset && (!m_wr[id] || !full)) begin
      for (int k = 0; k < n; k++) begin
        int i;
        i = (m_ptr[id] + k) % n;
        if (g < 0 && v[i]) g = i;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    check({p, "_ready"}, 32'(rdy), 32'(er));
    check({p, "_write"}, 32'(wr), 32'(m_wr[id]));
    check({p, "_data"}, od, m_dat[id]);
    check({p, "_count"}, cnt, m_cnt[id]);
    if (reset) begin
      m_wr[id]  = 1'b0;
      m_dat[id] = '0;
      m_cnt[id] = '0;
      m_ptr[id] = 0;
    end else begin
      if (m_wr[id] && !full) m_cnt[id] = m_cnt[id] + 32'd1;
      if (g >= 0) begin
        m_wr[id]  = 1'b1;
        m_dat[id] = dat[g*32 +: 32];
        m_ptr[id] = (g + 1) % n;
      end else if (m_wr[id] && !full) begin
        m_wr[id] = 1'b0;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_chk(0, 4, {4'b0, v4}, {128'b0, d4}, full4, {4'b0, rdy4}, wr4, od4, cnt4);
      model_chk(1, 3, {5'b0, v3}, {160'b0, d3}, full3, {5'b0, rdy3}, wr3, od3, cnt3);
      rdy4_seen = rdy4;
      if (!reset && wr4 && !full4) got4.push_back(od4);
      if (!reset && wr3 && !full3) got3.push_back(od3);
      if (fill_mode && !reset) begin
        if (full4 && fifo_q.size() > 0) outq.push_back(fifo_q.pop_front());
        if (wr4 && !full4) fifo_q.push_back(od4);
      end
    end
  end

  task automatic apply_auto();
    for (int i = 0; i < 4; i++) begin
      if (auto_en[i]) begin
        v4[i]          = (rq_cnt[i] < lim);
        d4[i*32 +: 32] = 32'(base[i] + stride * rq_cnt[i]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (auto_en[i] && rdy4_seen[i]) rq_cnt[i]++;
    end
    apply_auto();
    if (fill_mode) full4 = (fifo_q.size() >= 16);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    v4 = '0; v3 = '0; full4 = 1'b0; full3 = 1'b0; auto_en = '0; fill_mode = 1'b0;
    for (int i = 0; i < 4; i++) rq_cnt[i] = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_wr[i] = 1'b0; m_dat[i] = '0; m_cnt[i] = '0; m_ptr[i] = 0;
    end
    reset = 1'b1;
    v4 = '0; d4 = '0; full4 = 1'b0; v3 = '0; d3 = '0; full3 = 1'b0;
    rdy4_seen = '0; auto_en = '0; fill_mode = 1'b0; stride = 1; lim = 0;
    for (int i = 0; i < 4; i++) begin rq_cnt[i] = 0; base[i] = 0; end

    do_reset();
    @(negedge clk);
    check("rst_write", 32'(wr4), 32'd0);
    check("rst_data", od4, 32'd0);
    check("rst_count", cnt4, 32'd0);
    check("rst_ready", 32'(rdy4), 32'd0);

    // Reset while stalled holding 0x55
    step();
    v4 = 4'b0100; d4[64 +: 32] = 32'h55;
    step(); step();
    v4 = '0; full4 = 1'b1;
    step(); step();
    @(negedge clk);
    check("stall55_write", 32'(wr4), 32'd1);
    check("stall55_data", od4, 32'h55);
    check("stall55_count", cnt4, 32'd1);
    do_reset();
    @(negedge clk);
    check("midrst_write", 32'(wr4), 32'd0);
    check("midrst_data", od4, 32'd0);
    check("midrst_count", cnt4, 32'd0);
    step();
    v4 = 4'b1111; d4 = {32'd6, 32'd4, 32'd2, 32'd0};
    @(negedge clk);
    check("midrst_ptr_grant", 32'(rdy4), 32'b0001);

    // Single requester streaming 0x10, 0x12, ...
    do_reset();
    got4.delete();
    auto_en = 4'b0100; base[2] = 'h10; stride = 2; lim = 1000;
    apply_auto();
    repeat (6) step();
    auto_en = '0; v4 = '0;
    repeat (2) step();
    @(negedge clk);
    check("single_words", got4.size(), 32'd6);
    if (got4.size() == 6) begin
      check("single_w0", got4[0], 32'h10);
      check("single_w1", got4[1], 32'h12);
      check("single_w5", got4[5], 32'h1A);
    end
    check("single_count", cnt4, 32'd6);

    // Round robin, all four valid
    do_reset();
    got4.delete();
    v4 = 4'b1111; d4 = {32'd6, 32'd4, 32'd2, 32'd0};
    repeat (6) step();
    v4 = '0;
    repeat (2) step();
    @(negedge clk);
    check("rr_words", got4.size(), 32'd6);
    if (got4.size() == 6) begin
      for (int k = 0; k < 6; k++) check($sformatf("rr_w%0d", k), got4[k], 32'((k % 4) * 2));
    end

    // Full stall holding 0x06, then release
    do_reset();
    v4 = 4'b1111; d4 = {32'd6, 32'd4, 32'd2, 32'd0};
    repeat (4) step();
    full4 = 1'b1;
    repeat (5) step();
    @(negedge clk);
    check("stall_ready", 32'(rdy4), 32'd0);
    check("stall_write", 32'(wr4), 32'd1);
    check("stall_data", od4, 32'd6);
    step();
    full4 = 1'b0;
    step();
    @(negedge clk);
    check("release_data", od4, 32'd0);
    check("release_ready", 32'(rdy4), 32'b0010);
    step();
    v4 = '0;
    repeat (2) step();

    // Three requesters, pointer wrap with valid=101
    do_reset();
    got3.delete();
    v3 = 3'b101; d3 = {32'hA2, 32'hA1, 32'hA0};
    repeat (4) step();
    v3 = '0;
    repeat (2) step();
    @(negedge clk);
    check("wrap_words", got3.size(), 32'd4);
    if (got3.size() == 4) begin
      for (int k = 0; k < 4; k++) check($sformatf("wrap_w%0d", k), got3[k], (k % 2 == 0) ? 32'hA0 : 32'hA2);
    end

    // Fill a 16-deep fifo from two requesters, reader pops only while full
    do_reset();
    fifo_q.delete(); outq.delete();
    fill_mode = 1'b1;
    auto_en = 4'b0011; base[0] = 'h100; base[1] = 'h200; stride = 1; lim = 16;
    apply_auto();
    repeat (150) step();
    fill_mode = 1'b0; full4 = 1'b0;
    while (fifo_q.size() > 0) outq.push_back(fifo_q.pop_front());
    @(negedge clk);
    check("fill_words", outq.size(), 32'd32);
    check("fill_count", cnt4, 32'd32);
    if (outq.size() == 32) begin
      for (int k = 0; k < 32; k++)
        check($sformatf("fill_w%0d", k), outq[k], (k % 2 == 0) ? 32'(32'h100 + k / 2) : 32'(32'h200 + k / 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
